wb_sdram_bridge: RTL and testbench

Wishbone slave front-end that sits directly upstream of the SDRAM controller in the user project area. It decodes one 16 MB window and converts single Wishbone classic cycles into the controller's `in_valid`/`busy`/`out_valid` request protocol. Full-word writes are forwarded directly. Byte-masked writes are performed as read-modify-write. A read watchdog guarantees the bus never hangs.

---
 rtl/wb_sdram_bridge.sv | 187 ++++++++++++++++++
 tb/tb_wb_sdram_bridge.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sdram_bridge.sv
// Wishbone classic slave feeding the SDRAM controller request port.
// Single-word transfers; byte-masked writes run as read-modify-write.
module wb_sdram_bridge #(
  parameter logic [7:0]  BASE_ADDR = 8'h38,
  parameter logic [15:0] TIMEOUT   = 16'd1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [22:0] ctrl_addr,
  output logic        ctrl_rw,
  output logic [31:0] ctrl_wdata,
  output logic        ctrl_in_valid,
  input  logic [31:0] ctrl_rdata,
  input  logic        ctrl_busy,
  input  logic        ctrl_out_valid,
  output logic        err_o
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, ACK
  } state_t;

  state_t      state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [22:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [31:0] cwd_q, cwd_d;
  logic        iv_q, iv_d;
  logic        err_q, err_d;
  logic        abort_q, abort_d;
  logic        stale_q, stale_d;
  logic [15:0] timer_q, timer_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;

  logic        claim;
  logic        busy_st;
  logic [31:0] mask;
  logic [31:0] merged;
  logic        unused_adr;

  assign claim = wbs_cyc_i & wbs_stb_i & ~ack_q &
                 (wbs_adr_i[31:24] == BASE_ADDR);

  assign busy_st = (state_q == RD_REQ) |
                   (state_q == RD_WAIT) |
                   (state_q == WR_REQ);

  assign mask = {{8{sel_q[3]}}, {8{sel_q[2]}},
                 {8{sel_q[1]}}, {8{sel_q[0]}}};

  assign merged = (wdata_q & mask) | (ctrl_rdata & ~mask);

  // Word-aligned window: low byte bits and bit 23 do not select storage.
  assign unused_adr = ^{wbs_adr_i[23], wbs_adr_i[1:0]};

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    iv_d    = 1'b0;
    dat_d   = dat_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    cwd_d   = cwd_q;
    err_d   = err_q;
    abort_d = abort_q;
    stale_d = stale_q;
    timer_d = timer_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;

    // A response left over from a timed-out read is swallowed here.
    if (stale_q && ctrl_out_valid) stale_d = 1'b0;
    if (busy_st && !wbs_cyc_i) abort_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (claim) begin
          addr_d  = {wbs_adr_i[22:2], 2'b00};
          we_d    = wbs_we_i;
          sel_d   = wbs_sel_i;
          wdata_d = wbs_dat_i;
          if (wbs_we_i && wbs_sel_i == 4'h0)
            state_d = ACK;
          else if (wbs_we_i && wbs_sel_i == 4'hF)
            state_d = WR_REQ;
          else
            state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (!ctrl_busy && !stale_q) begin
          iv_d    = 1'b1;
          rw_d    = 1'b0;
          timer_d = 16'd0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        timer_d = timer_q + 16'd1;
        if (ctrl_out_valid) begin
          if (we_q) begin
            cwd_d   = merged;
            wdata_d = merged;
            state_d = WR_REQ;
          end else begin
            dat_d   = ctrl_rdata;
            state_d = ACK;
          end
        end else if (timer_q == TIMEOUT) begin
          err_d   = 1'b1;
          stale_d = 1'b1;
          dat_d   = 32'hDEADBEEF;
          state_d = ACK;
        end
      end
      WR_REQ: begin
        if (!ctrl_busy) begin
          iv_d    = 1'b1;
          rw_d    = 1'b1;
          cwd_d   = wdata_q;
          state_d = ACK;
        end
      end
      ACK: begin
        ack_d   = ~abort_q;
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      dat_q   <= 32'h0;
      addr_q  <= 23'h0;
      rw_q    <= 1'b0;
      cwd_q   <= 32'h0;
      iv_q    <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      stale_q <= 1'b0;
      timer_q <= 16'h0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      cwd_q   <= cwd_d;
      iv_q    <= iv_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      stale_q <= stale_d;
      timer_q <= timer_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
    end
  end

  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = dat_q;
  assign ctrl_addr     = addr_q;
  assign ctrl_rw       = rw_q;
  assign ctrl_wdata    = cwd_q;
  assign ctrl_in_valid = iv_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_wb_sdram_bridge.sv
// Bench for wb_sdram_bridge: directed plus random Wishbone traffic
// against a simple SDRAM responder and a word/byte-lane memory model.
module tb_wb_sdram_bridge;

  localparam logic [15:0] TMO = 16'd16;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [22:0] ctrl_addr;
  logic        ctrl_rw;
  logic [31:0] ctrl_wdata;
  logic        ctrl_in_valid;
  logic [31:0] ctrl_rdata = 32'h0;
  logic        ctrl_busy;
  logic        ctrl_out_valid = 1'b0;
  logic        err_o;

  always #5 clk = ~clk;

  wb_sdram_bridge #(.BASE_ADDR(8'h38), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .ctrl_addr(ctrl_addr), .ctrl_rw(ctrl_rw),
    .ctrl_wdata(ctrl_wdata), .ctrl_in_valid(ctrl_in_valid),
    .ctrl_rdata(ctrl_rdata), .ctrl_busy(ctrl_busy),
    .ctrl_out_valid(ctrl_out_valid), .err_o(err_o)
  );

  // Busy source: forced by directed steps or randomly toggled.
  logic busy_force = 1'b0;
  logic busy_rand  = 1'b0;
  logic busy_rnd   = 1'b0;
  always @(negedge clk) busy_rnd <= ($urandom_range(0, 3) == 0);
  assign ctrl_busy = busy_force | (busy_rand & busy_rnd);

  // SDRAM responder: stores writes, answers reads after rd_lat cycles.
  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       rq[$];
  logic [31:0] mem [logic [22:0]];
  int          cycn = 0, pulses = 0, consec = 0, acks = 0;
  int          rd_lat = 6;
  logic        prev_iv = 1'b0;
  logic        last_rw;
  logic [22:0] last_addr;
  logic [31:0] last_wdata;

  always @(posedge clk) begin
    cycn++;
    ctrl_out_valid <= 1'b0;
    if (wbs_ack_o) acks++;
    if (ctrl_in_valid) begin
      pulses++;
      if (prev_iv) consec++;
      last_rw    = ctrl_rw;
      last_addr  = ctrl_addr;
      last_wdata = ctrl_wdata;
      if (ctrl_rw)
        mem[ctrl_addr] = ctrl_wdata;
      else
        rq.push_back('{cycn + rd_lat,
          mem.exists(ctrl_addr) ? mem[ctrl_addr] : 32'h0});
    end
    prev_iv = ctrl_in_valid;
    for (int i = 0; i < rq.size(); i++) begin
      if (rq[i].due == cycn) begin
        ctrl_out_valid <= 1'b1;
        ctrl_rdata     <= rq[i].data;
        rq.delete(i);
        break;
      end
    end
  end

  // Reference memory: what each word should hold after the bus writes.
  logic [31:0] ref_mem [logic [22:0]];

  function automatic logic [31:0] ref_rd(input logic [22:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  function automatic logic [31:0] lane_merge(
    input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [22:0] key_of(input logic [31:0] adr);
    return {adr[22:2], 2'b00};
  endfunction

  int checks = 0, errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [3:0] sel,
                         input logic [31:0] adr, input logic [31:0] dat,
                         input int budget, output logic [31:0] rdat,
                         output int lat, output bit got);
    got  = 1'b0;
    lat  = -1;
    rdat = 32'h0;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    wbs_we_i = we; wbs_sel_i = sel;
    wbs_adr_i = adr; wbs_dat_i = dat;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin
        got = 1'b1; lat = n; rdat = wbs_dat_o;
        break;
      end
    end
    @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic bus_write(input logic [3:0] sel, input logic [31:0] adr,
                           input logic [31:0] dat, input string tag);
    logic [31:0] rd;
    int lat;
    bit got;
    wb_xfer(1'b1, sel, adr, dat, 100, rd, lat, got);
    check({tag, "_ack"}, 32'(got), 32'd1);
    if (sel != 4'h0)
      ref_mem[key_of(adr)] = lane_merge(ref_rd(key_of(adr)), dat, sel);
  endtask

  initial begin
    logic [31:0] rd, adr, dat;
    logic [3:0]  sel;
    logic        we;
    int          lat, p0, a0, exp_p;
    bit          got;

    rst = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'h0);
    check("rst_addr", 32'(ctrl_addr), 32'h0);
    check("rst_rw", 32'(ctrl_rw), 32'd0);
    check("rst_wdata", ctrl_wdata, 32'h0);
    check("rst_iv", 32'(ctrl_in_valid), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full-word write: one pulse, ack two cycles after the claim.
    p0 = pulses;
    wb_xfer(1'b1, 4'hF, 32'h3800_0010, 32'hA5A5_1234, 20, rd, lat, got);
    check("fw_ack", 32'(got), 32'd1);
    check("fw_lat", 32'(lat), 32'd2);
    check("fw_pulses", 32'(pulses - p0), 32'd1);
    check("fw_rw", 32'(last_rw), 32'd1);
    check("fw_addr", 32'(last_addr), 32'h10);
    check("fw_wdata", last_wdata, 32'hA5A5_1234);
    ref_mem[23'h10] = 32'hA5A5_1234;

    // Read back.
    p0 = pulses;
    wb_xfer(1'b0, 4'hF, 32'h3800_0010, 32'h0, 40, rd, lat, got);
    check("rd_ack", 32'(got), 32'd1);
    check("rd_data", rd, 32'hA5A5_1234);
    check("rd_pulses", 32'(pulses - p0), 32'd1);
    check("rd_rw", 32'(last_rw), 32'd0);
    check("rd_err", 32'(err_o), 32'd0);

    // Byte-masked write: read pulse, merged write pulse, single ack.
    bus_write(4'hF, 32'h3800_0040, 32'h1122_3344, "pre40");
    bus_write(4'hF, 32'h3800_0020, 32'h0BAD_F00D, "pre20");
    p0 = pulses; a0 = acks;
    wb_xfer(1'b1, 4'b0010, 32'h3800_0040, 32'h0000_7700, 60, rd, lat, got);
    check("rmw_ack", 32'(got), 32'd1);
    check("rmw_acks", 32'(acks - a0), 32'd1);
    check("rmw_pulses", 32'(pulses - p0), 32'd2);
    check("rmw_rw", 32'(last_rw), 32'd1);
    check("rmw_wdata", last_wdata, 32'h1122_7744);
    ref_mem[23'h40] = 32'h1122_7744;

    // Busy held for 20 cycles at the request.
    busy_force = 1'b1;
    p0 = pulses;
    dat = $urandom;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_sel_i = 4'hF; wbs_adr_i = 32'h3800_0030; wbs_dat_i = dat;
    repeat (20) @(negedge clk);
    check("busy_hold", 32'(pulses - p0), 32'd0);
    check("busy_iv", 32'(ctrl_in_valid), 32'd0);
    busy_force = 1'b0;
    @(posedge clk); #1;
    check("busy_first", 32'(ctrl_in_valid), 32'd1);
    got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin got = 1'b1; break; end
    end
    @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_ack", 32'(got), 32'd1);
    check("busy_wdata", last_wdata, dat);
    ref_mem[23'h30] = dat;

    // Random traffic with random busy and response latency.
    busy_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      we  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: sel = 4'hF;
        1: sel = 4'h0;
        default: sel = 4'($urandom);
      endcase
      adr = 32'h3800_0000 | (32'($urandom_range(0, 1)) << 23) |
            (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 3));
      dat = $urandom;
      rd_lat = $urandom_range(1, 8);
      if (!we) exp_p = 1;
      else if (sel == 4'hF) exp_p = 1;
      else if (sel == 4'h0) exp_p = 0;
      else exp_p = 2;
      p0 = pulses;
      wb_xfer(we, sel, adr, dat, 150, rd, lat, got);
      check($sformatf("rnd%0d_ack", t), 32'(got), 32'd1);
      check($sformatf("rnd%0d_pulses", t), 32'(pulses - p0), 32'(exp_p));
      if (!we)
        check($sformatf("rnd%0d_rdata", t), rd, ref_rd(key_of(adr)));
      else if (sel != 4'h0)
        ref_mem[key_of(adr)] =
          lane_merge(ref_rd(key_of(adr)), dat, sel);
    end
    busy_rand = 1'b0;
    check("rnd_err", 32'(err_o), 32'd0);

    // Read timeout, late response discarded, next read correct.
    rd_lat = 25;
    wb_xfer(1'b0, 4'hF, 32'h3800_0010, 32'h0, 40, rd, lat, got);
    check("tmo_ack", 32'(got), 32'd1);
    check("tmo_data", rd, 32'hDEAD_BEEF);
    check("tmo_err", 32'(err_o), 32'd1);
    check("tmo_lat", 32'(lat == 18 || lat == 19), 32'd1);
    rd_lat = 6;
    wb_xfer(1'b0, 4'hF, 32'h3800_0020, 32'h0, 80, rd, lat, got);
    check("post_ack", 32'(got), 32'd1);
    check("post_data", rd, ref_rd(23'h20));
    check("post_err", 32'(err_o), 32'd1);

    // Cycle dropped during an RMW read wait: write still lands, no ack.
    bus_write(4'hF, 32'h3800_0080, 32'hCAFE_BABE, "pre80");
    rd_lat = 10;
    p0 = pulses; a0 = acks;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_sel_i = 4'b0001; wbs_adr_i = 32'h3800_0080;
    wbs_dat_i = 32'h0000_00EE;
    repeat (4) @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (30) @(negedge clk);
    check("abt_acks", 32'(acks - a0), 32'd0);
    check("abt_pulses", 32'(pulses - p0), 32'd2);
    check("abt_rw", 32'(last_rw), 32'd1);
    check("abt_wdata", last_wdata, 32'hCAFE_BAEE);
    ref_mem[23'h80] = 32'hCAFE_BAEE;
    rd_lat = 6;

    // Address outside the window.
    p0 = pulses; a0 = acks;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0000;
    wbs_dat_i = 32'h1234_5678;
    repeat (10) @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    check("nomatch_pulses", 32'(pulses - p0), 32'd0);
    check("nomatch_acks", 32'(acks - a0), 32'd0);

    check("no_consec_iv", 32'(consec), 32'd0);
    foreach (ref_mem[k])
      check($sformatf("mem_%06h", k),
            mem.exists(k) ? mem[k] : 32'h0, ref_mem[k]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
